// File: rtl/rr_task_scheduler.sv
// Round-robin time-sliced scheduler for four task requesters.
// Drives the 4:1 task mux select and forwards the granted task ID.
module rr_task_scheduler #(
    parameter int QUANTUM = 4,
    parameter int CW      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] task_in0,
    input  logic [3:0] task_in1,
    input  logic [3:0] task_in2,
    input  logic [3:0] task_in3,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [3:0] task_out,
    output logic       busy,
    output logic       switch_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [CW-1:0] RELOAD = CW'(QUANTUM - 1);

    state_t        state, state_n;
    logic [3:0]    grant_n;
    logic [1:0]    sel_n;
    logic [1:0]    ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    start;
    logic [1:0]    win;
    logic          found;
    logic [3:0]    others;
    logic [3:0]    mux01;
    logic [3:0]    mux23;
    logic [3:0]    mux_out;

    // Rotating priority search; in SWITCH the scan starts after the old grantee
    always_comb begin
        start = (state == SWITCH) ? sel + 2'd1 : ptr;
        found = 1'b0;
        win   = start;
        for (int i = 3; i >= 0; i--) begin
            if (req[start + 2'(i)]) begin
                found = 1'b1;
                win   = start + 2'(i);
            end
        end
    end

    assign others = req & ~(4'b0001 << sel);

    // Next-state and next-register values for the slice FSM
    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = RUN;
                    grant_n = 4'b0001 << win;
                    sel_n   = win;
                    cnt_n   = RELOAD;
                end
            end
            RUN: begin
                if (!req[sel]) begin
                    state_n = SWITCH;
                    grant_n = 4'b0000;
                    cnt_n   = '0;
                end else if (cnt == '0 && others != 4'b0000) begin
                    state_n = SWITCH;
                    grant_n = 4'b0000;
                end else if (cnt == '0) begin
                    cnt_n = RELOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SWITCH: begin
                ptr_n = sel + 2'd1;
                if (found) begin
                    state_n = RUN;
                    grant_n = 4'b0001 << win;
                    sel_n   = win;
                    cnt_n   = RELOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    assign busy         = (state == RUN);
    assign switch_pulse = (state == SWITCH);

    // Task mux as a tree of 2:1 muxes on the registered select
    always_comb begin
        mux01    = sel[0] ? task_in1 : task_in0;
        mux23    = sel[0] ? task_in3 : task_in2;
        mux_out  = sel[1] ? mux23 : mux01;
        task_out = busy ? mux_out : 4'h0;
    end

    a_grant_onehot0 : assert property (
        @(posedge clk) disable iff (rst) $onehot0(grant));
    a_busy_grant : assert property (
        @(posedge clk) disable iff (rst) busy == (grant != 4'b0000));
    a_switch_single : assert property (
        @(posedge clk) disable iff (rst) switch_pulse |=> !switch_pulse);
    a_task_idle : assert property (
        @(posedge clk) disable iff (rst) !busy |-> task_out == 4'h0);

endmodule

// File: doc/rr_task_scheduler.md
Name: rr_task_scheduler

Overview:
- Round-robin, time-sliced scheduler for four task requesters sharing one 4-bit task datapath.
- Drives the 2-bit select of the 4:1 task mux, built as a tree of 2:1 4-bit muxes, and presents the selected task ID downstream.
- Each grant is held for a fixed quantum. A one-cycle context-switch gap separates consecutive grants.

Parameters:
- QUANTUM, 4: cycles per time slice. Legal range 1..2^CW.
- CW, 3: width of the slice counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester level request; bit i belongs to requester i.
- task_in0  input  4  task ID of requester 0.
- task_in1  input  4  task ID of requester 1.
- task_in2  input  4  task ID of requester 2.
- task_in3  input  4  task ID of requester 3.
- grant  output  4  one-hot grant, registered.
- sel  output  2  mux select (index of current/last grantee), registered.
- task_out  output  4  task_in[sel] while busy, else 4'h0 (combinational mux of registered sel).
- busy  output  1  high in RUN.
- switch_pulse  output  1  high for exactly the SWITCH cycle.

Behaviour:
- Reset: synchronous only; rst high at an edge forces on the next cycle:
  - state=IDLE, grant=0, sel=0, busy=0, switch_pulse=0, task_out=0;
  - rotation pointer ptr=0, slice counter cnt=0.
  - This applies in any state, including mid-RUN; no partial slice is resumed.
- State IDLE (grant=0, busy=0): if req!=0, arbitrate and go to RUN on the next edge; else stay IDLE.
- Arbitration: the winner is the first set bit of req scanning ptr, ptr+1, ... mod 4. On entering RUN:
  - grant=onehot(winner), sel=winner, cnt=QUANTUM-1.
  - Latency: req rising seen in IDLE at cycle t gives grant valid at cycle t+1.
- State RUN (busy=1, grant one-hot, task_out=task_in[sel]): cnt decrements each cycle. Evaluated each cycle, in priority order:
  - a) req[sel]==0: go to SWITCH (early release). Grant is still asserted in the cycle the drop is seen.
  - b) cnt==0 and req has another bit set: go to SWITCH (preemption).
  - c) cnt==0, req[sel]==1 and no other request: reload cnt=QUANTUM-1 and stay RUN. No switch_pulse; grant is unbroken.
  - d) otherwise: stay RUN with cnt-1.
- State SWITCH (one cycle):
  - grant=0, busy=0, switch_pulse=1, task_out=0; sel keeps the old value.
  - ptr <= sel+1 mod 4, so 3 wraps to 0.
  - At the end of the cycle, arbitrate on req with the updated rotation (start from sel+1): any req goes to RUN with the new winner, else IDLE.
  - The previous grantee may win again only if it is the sole requester.
- Simultaneous events: req drop and cnt==0 together are treated as an early release (one SWITCH, no reload).
- Slice lengths:
  - Full slice = QUANTUM busy cycles. Back-to-back contended slices have a period of QUANTUM+1 cycles.
  - With QUANTUM=1 under contention, each grant lasts 1 cycle followed by 1 SWITCH cycle.
- Invariants (assert):
  - grant is zero or one-hot;
  - busy==(grant!=0);
  - switch_pulse is never high in consecutive cycles;
  - task_out==0 whenever busy==0.
- Width rules: cnt is CW bits, unsigned, and never underflows (reloaded or left at 0 on exit). ptr and sel are 2-bit and wrap modulo 4.

Test Plan:
- Reset: assert rst 2 cycles with req=4'hF → grant=0, sel=0, busy=0, switch_pulse=0, task_out=0; first grant one cycle after rst drops is 4'b0001.
- Sole requester: req=4'b0100, task_in2=4'hA held 12 cycles → grant=4'b0100 and task_out=4'hA from cycle 1, continuous, switch_pulse never asserts.
- Full contention: QUANTUM=4, req=4'hF, task_inN=N+5 → grant sequence 0001×4, gap, 0010×4, gap, 0100×4, gap, 1000×4, gap, 0001 (wrap); task_out 5,6,7,8,5.
- Early release: req=4'b0011; drop req[0] on 2nd RUN cycle → SWITCH on the next cycle (2 busy cycles total), then grant=4'b0010 for 4 cycles.
- Pointer wrap and skip: grantee 3 expiring with req=4'b1001 → next grant 4'b0001. With req=4'b1000 only, grantee 3 keeps the grant via reload (no SWITCH).
- Mid-run reset: rst high in 3rd RUN cycle of grant 4'b0010 → next cycle all outputs 0, ptr=0; with req=4'hF the next grant is 4'b0001.
